// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box, 128-bit state type with byte helpers,
// stage FSM encoding and the ShiftRows byte mapping.
package aes_pkg;

  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Byte k sits in column k/4, row k%4; byte 0 occupies the MSBs.
  function automatic int byteIdx(int row, int col);
    return 4 * col + row;
  endfunction

  function automatic logic [7:0] getByte(state_t s, int k);
    return s[127 - 8*k -: 8];
  endfunction

  function automatic state_t shiftRows(state_t s);
    state_t r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*byteIdx(row, c) -: 8] = getByte(s, byteIdx(row, (c + row) % 4));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sbox8.sv
// Single forward AES S-box: purely combinational table lookup.
module sbox8
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] sub_o
);

  assign sub_o = SBOX[byte_i];

endmodule

// File: rtl/sub_shift_iter.sv
// Iterative SubBytes + ShiftRows: LANES shared S-boxes sweep the 16 bytes over
// 16/LANES cycles, then the ShiftRows view of the work register is held for MixColumns.
module sub_shift_iter #(
  parameter int LANES    = 4,
  parameter bit SHIFT_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  import aes_pkg::*;

  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  fsm_e          state_q;
  state_t        wreg_q;
  state_t        wreg_d;
  logic [CW-1:0] cnt_q;
  logic          out_valid_q;
  logic          busy_q;
  int            subBase;
  logic [7:0]    sbIn  [LANES];
  logic [7:0]    sbOut [LANES];

  // The modulo keeps the byte window inside the state even for counter values never reached.
  assign subBase = (int'(cnt_q) % NCYC) * LANES;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sbIn[l] = getByte(wreg_q, subBase + l);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sbox8 u_sbox (
      .byte_i (sbIn[g]),
      .sub_o  (sbOut[g])
    );
  end

  always_comb begin
    wreg_d = wreg_q;
    for (int l = 0; l < LANES; l++) begin
      wreg_d[127 - 8*(subBase + l) -: 8] = sbOut[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wreg_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            wreg_q  <= in_data;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SUB;
          end
        end
        SUB: begin
          wreg_q <= wreg_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(NCYC - 1)) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // in_ready is gated by rst directly so nothing can be offered during reset.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = SHIFT_EN ? shiftRows(wreg_q) : wreg_q;

endmodule

// File: tb/tb_sub_shift_iter.sv
// Self-checking bench for sub_shift_iter: directed FIPS-197 and boundary cases on four
// parameterisations, then a random stream against a GF(2^8)-derived AES reference model.
module tb_sub_shift_iter;

  localparam int NSTREAM = 100;

  logic         clk;
  logic         rst;
  logic [127:0] inData;
  logic         outReady;
  logic [3:0]   iv;
  logic [3:0]   ir;
  logic [3:0]   ov;
  logic [3:0]   bz;
  logic [127:0] od [4];

  int           nChecks;
  int           nFail;
  logic [7:0]   sboxRef [256];
  logic [127:0] q [$];

  // Instance 0: LANES=4 with ShiftRows; 1: LANES=4 raw; 2: LANES=8 raw; 3: LANES=16 raw.
  sub_shift_iter #(.LANES(4), .SHIFT_EN(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(inData),
    .out_valid(ov[0]), .out_ready(outReady), .out_data(od[0]), .busy(bz[0]));
  sub_shift_iter #(.LANES(4), .SHIFT_EN(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(inData),
    .out_valid(ov[1]), .out_ready(outReady), .out_data(od[1]), .busy(bz[1]));
  sub_shift_iter #(.LANES(8), .SHIFT_EN(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(inData),
    .out_valid(ov[2]), .out_ready(outReady), .out_data(od[2]), .busy(bz[2]));
  sub_shift_iter #(.LANES(16), .SHIFT_EN(1'b0)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(inData),
    .out_valid(ov[3]), .out_ready(outReady), .out_data(od[3]), .busy(bz[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sboxRef[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] refSub(logic [127:0] s, bit shiftEn);
    logic [7:0]   b [16];
    logic [127:0] r;
    int           src;
    for (int k = 0; k < 16; k++) b[k] = sboxRef[s[127 - 8*k -: 8]];
    for (int k = 0; k < 16; k++) begin
      src = shiftEn ? 4 * (((k / 4) + (k % 4)) % 4) + (k % 4) : k;
      r[127 - 8*k -: 8] = b[src];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one state to instance idx, measure edges until out_valid, check result, then drain.
  task automatic applyStimulus(input int idx, input logic [127:0] d, input logic rdy,
                               input int expLat, input logic [127:0] expOut, input string tag);
    int n;
    n        = 0;
    inData   = d;
    outReady = rdy;
    checkOutput({tag, " in_ready idle"}, ir[idx], 1'b1);
    iv[idx] = 1'b1;
    do begin
      tick();
      iv[idx] = 1'b0;
      n++;
    end while (!ov[idx] && n < 30);
    checkOutput({tag, " latency"}, n, expLat);
    checkOutput({tag, " data"}, od[idx], expOut);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkOutput({tag, " out_valid drop"}, ov[idx], 1'b0);
    checkOutput({tag, " back to idle"}, ir[idx], 1'b1);
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] held;
    int           sent;
    int           got;
    int           cyc;

    nChecks  = 0;
    nFail    = 0;
    rst      = 1'b1;
    iv       = '0;
    inData   = '0;
    outReady = 1'b0;
    buildSbox();

    tick();
    tick();
    checkOutput("reset out_valid", ov[0], 1'b0);
    checkOutput("reset busy", bz[0], 1'b0);
    checkOutput("reset out_data", od[0], 128'h0);
    checkOutput("reset in_ready low", ir[0], 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("in_ready after reset", ir[0], 1'b1);

    applyStimulus(0, 128'h0, 1'b1, 5, {16{8'h63}}, "zero state");
    applyStimulus(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 5,
                  128'hd4bf5d30e0b452aeb84111f11e2798e5, "fips shift");
    applyStimulus(1, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 5,
                  128'hd42711aee0bf98f1b8b45de51e415230, "fips noshift");

    // Reset during the second SUB cycle discards the state.
    inData = {$urandom, $urandom, $urandom, $urandom};
    iv[0]  = 1'b1;
    tick();
    iv[0] = 1'b0;
    checkOutput("midsub busy", bz[0], 1'b1);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("midsub reset out_valid", ov[0], 1'b0);
    checkOutput("midsub reset busy", bz[0], 1'b0);
    checkOutput("midsub reset out_data", od[0], 128'h0);
    checkOutput("midsub in_ready during rst", ir[0], 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("midsub in_ready after rst", ir[0], 1'b1);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("midsub no late output", ov[0], 1'b0);

    // Backpressure: state waits in DONE while in_valid stays high.
    d      = {$urandom, $urandom, $urandom, $urandom};
    inData = d;
    iv[0]  = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("bp out_valid", ov[0], 1'b1);
    checkOutput("bp data", od[0], refSub(d, 1'b1));
    held = od[0];
    for (int i = 0; i < 10; i++) begin
      inData = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checkOutput("bp hold valid", ov[0], 1'b1);
      checkOutput("bp hold data", od[0], held);
      checkOutput("bp in_ready", ir[0], 1'b0);
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkOutput("bp release valid", ov[0], 1'b0);
    checkOutput("bp release idle", ir[0], 1'b1);
    iv[0] = 1'b0;
    tick();

    d = {8'h00, 8'h53, 8'hff, 8'h00, 8'h53, 8'hff, 8'h00, 8'h53,
         8'hff, 8'h00, 8'h53, 8'hff, 8'h00, 8'h53, 8'hff, 8'h00};
    held = {8'h63, 8'hed, 8'h16, 8'h63, 8'hed, 8'h16, 8'h63, 8'hed,
            8'h16, 8'h63, 8'hed, 8'h16, 8'h63, 8'hed, 8'h16, 8'h63};
    applyStimulus(1, d, 1'b0, 5, held, "spot lanes4");
    applyStimulus(2, d, 1'b0, 3, held, "spot lanes8");
    applyStimulus(3, d, 1'b1, 2, held, "spot lanes16");
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(2, d, 1'($urandom_range(0, 1)), 3, refSub(d, 1'b0), "rand lanes8");
      d = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(3, d, 1'($urandom_range(0, 1)), 2, refSub(d, 1'b0), "rand lanes16");
    end

    // Random stream with scoreboard on instance 0.
    q.delete();
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((sent < NSTREAM || got < NSTREAM) && cyc < 5000) begin
      iv[0]    = (sent < NSTREAM) && ($urandom_range(0, 3) != 0);
      inData   = {$urandom, $urandom, $urandom, $urandom};
      outReady = ($urandom_range(0, 2) != 0);
      if (iv[0] && ir[0]) begin
        q.push_back(refSub(inData, 1'b1));
        sent++;
      end
      if (ov[0] && outReady) begin
        checkOutput("stream output expected", q.size() != 0, 1'b1);
        if (q.size() != 0) checkOutput("stream data", od[0], q.pop_front());
        got++;
      end
      tick();
      cyc++;
    end
    iv[0]    = 1'b0;
    outReady = 1'b0;
    checkOutput("stream sent", sent, NSTREAM);
    checkOutput("stream received", got, NSTREAM);
    checkOutput("stream leftover", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
